// File: rtl/fp_sqrt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_sqrt_pkg : shared constants and types of the FP square-root unit   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package fp_sqrt_pkg;

  // Register-file address map
  localparam logic [2:0] ADDR_ZERO = 3'd0;
  localparam logic [2:0] ADDR_N    = 3'd1;
  localparam logic [2:0] ADDR_X    = 3'd2;
  localparam logic [2:0] ADDR_ROOT = 3'd3;
  localparam logic [2:0] ADDR_TEMP = 3'd4;
  localparam logic [2:0] ADDR_TWO  = 3'd5;
  localparam logic [2:0] ADDR_EPS  = 3'd6;
  localparam logic [2:0] ADDR_SCR  = 3'd7;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_DIV = 2'b10,
    ALU_ABS = 2'b11
  } alu_op_e;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_TWO     = 32'h4000_0000;
  localparam logic [31:0] FP_EPS_DEF = 32'h3A83_126F;

  // Constant slots (0, 5, 6) silently drop writes.
  function automatic logic addr_writable(input logic [2:0] addr);
    return (addr == ADDR_N) || (addr == ADDR_X) || (addr == ADDR_ROOT) ||
           (addr == ADDR_TEMP) || (addr == ADDR_SCR);
  endfunction

endpackage : fp_sqrt_pkg
`default_nettype wire

// File: rtl/fp_regfile_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_regfile_if : control word and data bus between controller and RF  |
// | Revision      : 1.0  (iter_cnt present only with FP_RF_ITER_CNT_EN)  |
// +----------------------------------------------------------------------+
interface fp_regfile_if #(
  parameter int CNT_W = 8
);
  logic        IE;
  logic        WE;
  logic        OE;
  logic [2:0]  ADDR_WR;
  logic [2:0]  ADDR_RDA;
  logic [2:0]  ADDR_RDB;
  logic [31:0] din;
  logic [31:0] alu_res;
  logic [31:0] rda_data;
  logic [31:0] rdb_data;
  logic [31:0] dout;
  logic        out_valid;
  logic        converged;
`ifdef FP_RF_ITER_CNT_EN
  logic [CNT_W-1:0] iter_cnt;
`endif

  modport master (
    output IE, WE, OE, ADDR_WR, ADDR_RDA, ADDR_RDB, din, alu_res,
    input  rda_data, rdb_data, dout, out_valid, converged
`ifdef FP_RF_ITER_CNT_EN
    , input iter_cnt
`endif
  );

  modport slave (
    input  IE, WE, OE, ADDR_WR, ADDR_RDA, ADDR_RDB, din, alu_res,
    output rda_data, rdb_data, dout, out_valid, converged
`ifdef FP_RF_ITER_CNT_EN
    , output iter_cnt
`endif
  );

endinterface : fp_regfile_if
`default_nettype wire

// File: rtl/fp_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_regfile : 8x32 operand register file of the FP sqrt datapath      |
// | Optional iteration counter under macro FP_RF_ITER_CNT_EN             |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module fp_regfile
  import fp_sqrt_pkg::*;
#(
  parameter logic [31:0] TWO_VAL = FP_TWO,
  parameter logic [31:0] EPS_VAL = FP_EPS_DEF,
  parameter int          CNT_W   = 8
) (
  input  wire logic   clk,
  input  wire logic   rst,
  fp_regfile_if.slave rf
);

  logic [31:0] reg_n;
  logic [31:0] reg_x;
  logic [31:0] reg_root;
  logic [31:0] reg_temp;
  logic [31:0] reg_scr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] rda_mux;
  logic [31:0] rdb_mux;
  logic        oe_prev;
  logic        oe_rise;
  logic [31:0] dout_q;
  logic        out_valid_q;
  logic        converged_q;

  assign wr_data = rf.IE ? rf.din : rf.alu_res;
  assign wr_en   = rf.WE && addr_writable(rf.ADDR_WR);
  assign oe_rise = rf.OE && !oe_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_n    <= '0;
      reg_x    <= '0;
      reg_root <= '0;
      reg_temp <= '0;
      reg_scr  <= '0;
    end else if (wr_en) begin
      unique case (rf.ADDR_WR)
        ADDR_N:    reg_n    <= wr_data;
        ADDR_X:    reg_x    <= wr_data;
        ADDR_ROOT: reg_root <= wr_data;
        ADDR_TEMP: reg_temp <= wr_data;
        ADDR_SCR:  reg_scr  <= wr_data;
        default:   ;
      endcase
    end
  end

  // Reads see stored state only; a same-cycle write is not forwarded.
  always_comb begin
    rda_mux = FP_ZERO;
    unique case (rf.ADDR_RDA)
      ADDR_ZERO: rda_mux = FP_ZERO;
      ADDR_N:    rda_mux = reg_n;
      ADDR_X:    rda_mux = reg_x;
      ADDR_ROOT: rda_mux = reg_root;
      ADDR_TEMP: rda_mux = reg_temp;
      ADDR_TWO:  rda_mux = TWO_VAL;
      ADDR_EPS:  rda_mux = EPS_VAL;
      ADDR_SCR:  rda_mux = reg_scr;
      default:   rda_mux = FP_ZERO;
    endcase
  end

  always_comb begin
    rdb_mux = FP_ZERO;
    unique case (rf.ADDR_RDB)
      ADDR_ZERO: rdb_mux = FP_ZERO;
      ADDR_N:    rdb_mux = reg_n;
      ADDR_X:    rdb_mux = reg_x;
      ADDR_ROOT: rdb_mux = reg_root;
      ADDR_TEMP: rdb_mux = reg_temp;
      ADDR_TWO:  rdb_mux = TWO_VAL;
      ADDR_EPS:  rdb_mux = EPS_VAL;
      ADDR_SCR:  rdb_mux = reg_scr;
      default:   rdb_mux = FP_ZERO;
    endcase
  end

  assign rf.rda_data = rda_mux;
  assign rf.rdb_data = rdb_mux;

  // Sign of temp = |root-x| - eps: set means the iteration is within tolerance.
  always_ff @(posedge clk) begin
    if (rst) begin
      converged_q <= 1'b0;
    end else if (rf.WE && (rf.ADDR_WR == ADDR_TEMP)) begin
      converged_q <= wr_data[31];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oe_prev     <= 1'b0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      oe_prev     <= rf.OE;
      out_valid_q <= oe_rise;
      if (oe_rise) begin
        dout_q <= rda_mux;
      end
    end
  end

  assign rf.dout      = dout_q;
  assign rf.out_valid = out_valid_q;
  assign rf.converged = converged_q;

`ifdef FP_RF_ITER_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] iter_cnt_q;

  // Loading a new n restarts the count and takes precedence over an increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt_q <= '0;
    end else if (rf.WE && rf.IE) begin
      iter_cnt_q <= '0;
    end else if (rf.WE && (rf.ADDR_WR == ADDR_X) && (iter_cnt_q != CNT_MAX)) begin
      iter_cnt_q <= iter_cnt_q + 1'b1;
    end
  end

  assign rf.iter_cnt = iter_cnt_q;
`endif

endmodule : fp_regfile
`default_nettype wire

// File: tb/tb_fp_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp_regfile : directed self-checking bench for fp_regfile          |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_fp_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   ov_cnt;

  always #5 clk = ~clk;

  fp_regfile_if #(.CNT_W(8)) bus ();

  fp_regfile dut (
    .clk (clk),
    .rst (rst),
    .rf  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.IE = 1'b0; bus.WE = 1'b0; bus.OE = 1'b0;
    bus.ADDR_WR = 3'd0; bus.ADDR_RDA = 3'd0; bus.ADDR_RDB = 3'd0;
    bus.din = '0; bus.alu_res = '0;
  endtask

  task automatic wr(input logic ie, input logic [2:0] a, input logic [31:0] d);
    bus.WE = 1'b1; bus.IE = ie; bus.ADDR_WR = a;
    if (ie) bus.din = d; else bus.alu_res = d;
    tick();
    bus.WE = 1'b0; bus.IE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.ADDR_RDA = a;
    bus.ADDR_RDB = 3'(7 - a);
    #1;
    check({tag, "_A"}, bus.rda_data, exp);
  endtask

  localparam logic [31:0] RESET_IMG [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                             32'h4000_0000, 32'h3A83_126F, 32'h0};

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset image across both ports
    for (int i = 0; i < 8; i++) begin
      bus.ADDR_RDA = 3'(i);
      bus.ADDR_RDB = 3'(i);
      #1;
      check($sformatf("rst_rda%0d", i), bus.rda_data, RESET_IMG[i]);
      check($sformatf("rst_rdb%0d", i), bus.rdb_data, RESET_IMG[i]);
    end
    check("rst_dout", bus.dout, 32'h0);
    check("rst_ovld", {31'b0, bus.out_valid}, 32'h0);
    check("rst_conv", {31'b0, bus.converged}, 32'h0);

    // Load n = 9.0; same-cycle read still shows the old value
    bus.WE = 1'b1; bus.IE = 1'b1; bus.ADDR_WR = 3'd1; bus.din = 32'h4110_0000;
    bus.ADDR_RDA = 3'd1;
    #1;
    check("n_same_cycle", bus.rda_data, 32'h0);
    tick();
    bus.WE = 1'b0; bus.IE = 1'b0;
    check("n_after", bus.rda_data, 32'h4110_0000);

    // Writes to constant slots are ignored
    wr(1'b0, 3'd5, 32'h3F80_0000);
    rd_chk("const5", 3'd5, 32'h4000_0000);
    wr(1'b0, 3'd0, 32'h3F80_0000);
    rd_chk("const0", 3'd0, 32'h0);
    wr(1'b1, 3'd6, 32'h3F80_0000);
    rd_chk("const6", 3'd6, 32'h3A83_126F);

    // Write-data select: alu_res path with din carrying a decoy
    bus.din = 32'hDEAD_BEEF;
    wr(1'b0, 3'd7, 32'h1234_5678);
    rd_chk("scr_alu", 3'd7, 32'h1234_5678);
    bus.ADDR_RDB = 3'd7;
    #1;
    check("scr_rdb", bus.rdb_data, 32'h1234_5678);

    // Convergence flag follows temp sign
    wr(1'b0, 3'd4, 32'hBA00_0000);
    check("conv_neg", {31'b0, bus.converged}, 32'h1);
    rd_chk("temp_neg", 3'd4, 32'hBA00_0000);
    wr(1'b0, 3'd4, 32'h3A00_0000);
    check("conv_pos", {31'b0, bus.converged}, 32'h0);
    wr(1'b0, 3'd7, 32'h8000_0000);
    check("conv_hold", {31'b0, bus.converged}, 32'h0);
    wr(1'b0, 3'd4, 32'hBF80_0000);
    check("conv_neg2", {31'b0, bus.converged}, 32'h1);

    // Output latch on OE rising edge
    wr(1'b1, 3'd3, 32'h4040_0000);
    bus.ADDR_RDA = 3'd3;
    bus.OE = 1'b1;
    ov_cnt = 0;
    tick();
    check("oe_dout", bus.dout, 32'h4040_0000);
    check("oe_ovld1", {31'b0, bus.out_valid}, 32'h1);
    if (bus.out_valid) ov_cnt++;
    // Change root while OE stays high
    bus.WE = 1'b1; bus.IE = 1'b1; bus.ADDR_WR = 3'd3; bus.din = 32'h40A0_0000;
    tick();
    bus.WE = 1'b0; bus.IE = 1'b0;
    check("oe_ovld2", {31'b0, bus.out_valid}, 32'h0);
    if (bus.out_valid) ov_cnt++;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bus.out_valid) ov_cnt++;
    end
    check("oe_hold_dout", bus.dout, 32'h4040_0000);
    check("oe_root_new", bus.rda_data, 32'h40A0_0000);
    check("oe_strobes", 32'(ov_cnt), 32'd1);
    bus.OE = 1'b0;
    tick();
    check("oe_low_dout", bus.dout, 32'h4040_0000);
    bus.OE = 1'b1;
    tick();
    check("oe_relatch", bus.dout, 32'h40A0_0000);
    check("oe_restrobe", {31'b0, bus.out_valid}, 32'h1);
    bus.OE = 1'b0;
    tick();

`ifdef FP_RF_ITER_CNT_EN
    wr(1'b1, 3'd1, 32'h4110_0000);
    check("cnt_clr", 32'(bus.iter_cnt), 32'd0);
    for (int k = 0; k < 3; k++) wr(1'b0, 3'd2, 32'h4000_0000 + 32'(k));
    check("cnt_3", 32'(bus.iter_cnt), 32'd3);
    wr(1'b1, 3'd2, 32'h4040_0000);
    check("cnt_ie_clr", 32'(bus.iter_cnt), 32'd0);
    for (int k = 0; k < 3; k++) wr(1'b0, 3'd2, 32'h4000_0000 + 32'(k));
`else
    for (int k = 0; k < 3; k++) wr(1'b0, 3'd2, 32'h4000_0000 + 32'(k));
`endif
    rd_chk("x_pre_rst", 3'd2, 32'h4000_0002);

    // Reset coincident with a write discards everything
    rst = 1'b1;
    bus.WE = 1'b1; bus.IE = 1'b0; bus.ADDR_WR = 3'd2; bus.alu_res = 32'h4080_0000;
    tick();
    rst = 1'b0;
    bus.WE = 1'b0;
`ifdef FP_RF_ITER_CNT_EN
    check("cnt_rst", 32'(bus.iter_cnt), 32'd0);
`endif
    rd_chk("x_rst", 3'd2, 32'h0);
    rd_chk("n_rst", 3'd1, 32'h0);
    rd_chk("root_rst", 3'd3, 32'h0);
    check("dout_rst", bus.dout, 32'h0);
    check("conv_rst", {31'b0, bus.converged}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_fp_regfile
`default_nettype wire

// File: doc/fp_regfile.md
# fp_regfile

Register-file datapath for the floating-point square-root unit: the consumer of the controller's decoded control word (IE, WE, OE, ADDR_WR, ADDR_RDA, ADDR_RDB). It holds the eight 32-bit IEEE-754 single-precision operands of the Newton iteration and feeds two read ports to the external combinational FP ALU. It also selects write-back data between external input and the ALU result. It latches the final root on OE and reports a convergence status back to the controller's next-state logic.

## Interface
Parameters:
- TWO_VAL, 32'h4000_0000, constant 2.0 held at address 5
- EPS_VAL, 32'h3A83_126F, tolerance (0.001) held at address 6
- CNT_W, 8, iteration counter width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- IE  in  1  write-data select: 1 = din, 0 = alu_res
- WE  in  1  write enable
- OE  in  1  output enable (final-result state)
- ADDR_WR  in  3  write address
- ADDR_RDA  in  3  read port A address
- ADDR_RDB  in  3  read port B address
- din  in  32  external operand n
- alu_res  in  32  FP ALU result
- rda_data  out  32  port A data to ALU
- rdb_data  out  32  port B data to ALU
- dout  out  32  latched result
- out_valid  out  1  one-cycle result strobe
- converged  out  1  sign of last value written to temp (address 4)
- iter_cnt  out  CNT_W  iteration count (only with macro)

## Operation
- Map: 0 = 0.0 (const), 1 = n, 2 = x, 3 = root, 4 = temp, 5 = TWO_VAL (const), 6 = EPS_VAL (const), 7 = scratch.
- Writable: 1, 2, 3, 4, 7. WE to 0, 5 or 6 is silently ignored.
- wr_data = IE ? din : alu_res. Written on the clock edge when WE=1.
- Reads are combinational from stored state. No write-to-read forwarding: the same-cycle read of the address being written returns the old value.
- converged: on WE with ADDR_WR=4, load wr_data[31]. Otherwise hold. 1 means temp = |root−x|−eps is negative, so iteration is done.
- Output: on the first cycle with OE=1, where the previous cycle had OE=0 (registered edge detect):
  - dout loads rda_data.
  - out_valid is 1 in the following cycle only.
  - OE held high re-strobes nothing. dout holds until the next OE rising edge or reset.
- OE and WE both high: both actions occur independently.

## Timing
- Reset values: regs 1,2,3,4,7 = 0. dout = 0. out_valid = 0. converged = 0. OE-edge history = 0. iter_cnt = 0.
- rst has priority over every write, latch and count in the same cycle. Reset mid-iteration discards all state.
- Write latency 1: data is visible on the read ports the cycle after WE.
- Read latency 0, combinational from ADDR_RDA/ADDR_RDB.
- out_valid is asserted one cycle after the OE rising edge and lasts exactly one cycle.
- converged is valid one cycle after the temp write.

## Configuration
- FP_RF_ITER_CNT_EN defined:
  - iter_cnt port and counter exist.
  - Cleared on WE&IE (new n loaded).
  - Increments on each WE with ADDR_WR=2 and IE=0.
  - Saturates at 2^CNT_W−1.
  - Clear wins over increment.
- Undefined: port and counter absent. All other behaviour is identical.

## Structure
- Shared package fp_sqrt_pkg:
  - Address constants: ADDR_ZERO, ADDR_N, ADDR_X, ADDR_ROOT, ADDR_TEMP, ADDR_TWO, ADDR_EPS, ADDR_SCR.
  - ALU_Op encoding: ADD=00, SUB=01, DIV=10, ABS=11.
  - FP constants: 2.0 and default epsilon.
- Single module, no sub-module. The output latch and edge detect are inline.

## Test plan
- Reset, then read all 8 addresses -> 0 for 0–4 and 7. Addr 5 = 32'h40000000. Addr 6 = 32'h3A83126F. dout = 0, out_valid = 0, converged = 0.
- IE=1, WE=1, ADDR_WR=1, din=32'h41100000 (9.0) -> next cycle rda_data (RDA=1) = 32'h41100000. Same-cycle read of addr 1 still shows 0.
- WE=1, IE=0, ADDR_WR=5, alu_res=32'h3F800000 -> addr 5 remains 32'h40000000. Same result for addresses 0 and 6.
- WE to addr 4:
  - alu_res=32'hBA000000 -> converged=1 next cycle.
  - Then alu_res=32'h3A000000 -> converged=0.
- Reg 3 = 32'h40400000 (3.0), RDA=3, OE held high 4 cycles:
  - dout = 32'h40400000.
  - out_valid high exactly one cycle.
  - Change reg 3 while OE stays high -> dout unchanged.
- With FP_RF_ITER_CNT_EN:
  - Load n, then 3 writes to addr 2 with IE=0 -> iter_cnt=3.
  - rst asserted in the same cycle as a 4th write -> iter_cnt=0 and reg 2 = 0.
